// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched: grants the shared WS2812 strip to one of three pixel
// sources per frame, steers the pixel mux, starts the serial driver, guards
// the frame with a watchdog, enforces the latch gap and a minimum frame period.
module ws2812_frame_sched #(
   parameter int RST_GAP_CYC   = 15000,
   parameter int FRAME_MIN_CYC = 1000000,
   parameter int TIMEOUT_CYC   = 200000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [2:0] req,
   input  logic       frame_done,
   output logic [2:0] gnt,
   output logic [1:0] src_sel,
   output logic       frame_start,
   output logic [2:0] ack,
   output logic       timeout,
   output logic       busy
);

   localparam int PW = (FRAME_MIN_CYC > 1) ? $clog2(FRAME_MIN_CYC) : 1;
   localparam int WW = (TIMEOUT_CYC > 1)   ? $clog2(TIMEOUT_CYC)   : 1;
   localparam int GW = (RST_GAP_CYC > 1)   ? $clog2(RST_GAP_CYC)   : 1;

   localparam logic [PW-1:0] PERIOD_MAX  = PW'(FRAME_MIN_CYC - 1);
   localparam logic [PW-1:0] PERIOD_ONE  = PW'(1);
   // The frame_start cycle itself is the first cycle of the new period, so the
   // next frame_start lands exactly FRAME_MIN_CYC cycles later.
   localparam logic [PW-1:0] PERIOD_LOAD = (FRAME_MIN_CYC > 1) ? PW'(1) : PW'(0);
   localparam logic [WW-1:0] WDOG_MAX    = WW'(TIMEOUT_CYC - 1);
   localparam logic [WW-1:0] WDOG_ONE    = WW'(1);
   localparam logic [GW-1:0] GAP_MAX     = GW'(RST_GAP_CYC - 1);
   localparam logic [GW-1:0] GAP_ONE     = GW'(1);
   localparam logic [1:0]    SRC_BLANK   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_START,
      ST_SEND,
      ST_GAP
   } state_t;

   state_t        state_q;
   logic [2:0]    gnt_q;
   logic [1:0]    src_sel_q;
   logic          frame_start_q;
   logic [2:0]    ack_q;
   logic          timeout_q;
   logic          busy_q;
   logic          rr_q;        // 0: req[1] preferred, 1: req[2] preferred
   logic [PW-1:0] period_q;
   logic [WW-1:0] wdog_q;
   logic [GW-1:0] gap_q;

   logic [2:0]    win_gnt_d;
   logic [1:0]    win_src_d;
   logic          period_ok;

   assign period_ok = (period_q == PERIOD_MAX);

   // Winner selection: urgent flash first, then round-robin between snake and roll
   always_comb begin
      win_gnt_d = 3'b000;
      win_src_d = SRC_BLANK;
      if (req[0]) begin
         win_gnt_d = 3'b001;
         win_src_d = 2'd0;
      end else if (req[1] && (!req[2] || !rr_q)) begin
         win_gnt_d = 3'b010;
         win_src_d = 2'd1;
      end else if (req[2]) begin
         win_gnt_d = 3'b100;
         win_src_d = 2'd2;
      end
   end

   // Scheduler FSM with its counters and all registered outputs
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q       <= ST_IDLE;
         gnt_q         <= 3'b000;
         src_sel_q     <= SRC_BLANK;
         frame_start_q <= 1'b0;
         ack_q         <= 3'b000;
         timeout_q     <= 1'b0;
         busy_q        <= 1'b0;
         rr_q          <= 1'b0;
         period_q      <= PERIOD_MAX;
         wdog_q        <= '0;
         gap_q         <= '0;
      end else begin
         frame_start_q <= 1'b0;
         ack_q         <= 3'b000;
         timeout_q     <= 1'b0;

         if (period_q != PERIOD_MAX) begin
            period_q <= period_q + PERIOD_ONE;
         end

         case (state_q)
            ST_IDLE: begin
               if ((req != 3'b000) && period_ok) begin
                  gnt_q     <= win_gnt_d;
                  src_sel_q <= win_src_d;
                  busy_q    <= 1'b1;
                  state_q   <= ST_GRANT;
                  // Urgent grants leave the round-robin pointer alone
                  if (!req[0]) begin
                     rr_q <= (win_src_d == 2'd1);
                  end
               end
            end

            ST_GRANT: begin
               // src_sel has been stable for a full cycle; launch the driver
               frame_start_q <= 1'b1;
               period_q      <= PERIOD_LOAD;
               wdog_q        <= '0;
               state_q       <= ST_START;
            end

            ST_START: begin
               if (wdog_q != WDOG_MAX) begin
                  wdog_q <= wdog_q + WDOG_ONE;
               end
               state_q <= ST_SEND;
            end

            ST_SEND: begin
               if (frame_done) begin
                  ack_q     <= gnt_q;
                  gnt_q     <= 3'b000;
                  src_sel_q <= SRC_BLANK;
                  gap_q     <= '0;
                  state_q   <= ST_GAP;
               end else if (wdog_q == WDOG_MAX) begin
                  timeout_q <= 1'b1;
                  gnt_q     <= 3'b000;
                  src_sel_q <= SRC_BLANK;
                  gap_q     <= '0;
                  state_q   <= ST_GAP;
               end else begin
                  wdog_q <= wdog_q + WDOG_ONE;
               end
            end

            ST_GAP: begin
               if (gap_q == GAP_MAX) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_q + GAP_ONE;
               end
            end

            default: begin
               gnt_q     <= 3'b000;
               src_sel_q <= SRC_BLANK;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt         = gnt_q;
   assign src_sel     = src_sel_q;
   assign frame_start = frame_start_q;
   assign ack         = ack_q;
   assign timeout     = timeout_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Testbench for ws2812_frame_sched: directed frames with a scoreboard of
// expected output events and per-cycle output snapshots.
`timescale 1ns/1ps
module tb_ws2812_frame_sched;

   localparam int GAP  = 4;
   localparam int FMIN = 20;
   localparam int TMO  = 50;

   logic       sys_clk    = 1'b0;
   logic       sys_rst_n  = 1'b0;
   logic [2:0] req        = 3'b000;
   logic       frame_done = 1'b0;
   logic [2:0] gnt;
   logic [1:0] src_sel;
   logic       frame_start;
   logic [2:0] ack;
   logic       timeout;
   logic       busy;

   ws2812_frame_sched #(
      .RST_GAP_CYC   (GAP),
      .FRAME_MIN_CYC (FMIN),
      .TIMEOUT_CYC   (TMO)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .req         (req),
      .frame_done  (frame_done),
      .gnt         (gnt),
      .src_sel     (src_sel),
      .frame_start (frame_start),
      .ack         (ack),
      .timeout     (timeout),
      .busy        (busy)
   );

   always #5 sys_clk = ~sys_clk;

   // cycle n = the cycle following the n-th rising edge
   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;   // 0 frame_start, 1 ack, 2 timeout
      logic [2:0] val;    // gnt for frame_start, ack vector for ack
      logic [1:0] src;
      int         at;
   } ev_t;

   typedef struct {
      int          at;
      logic [10:0] v;     // {gnt, src_sel, busy, frame_start, ack, timeout}
   } snap_t;

   ev_t   ev_q[$];
   snap_t snap_q[$];

   int chk_cnt  = 0;
   int pass_cnt = 0;
   bit fin      = 1'b0;

   int last_start = -1000;
   int idle_at    = 0;
   int req_cyc    = 0;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic string kname(input int k);
      case (k)
         0:       return "frame_start";
         1:       return "ack";
         default: return "timeout";
      endcase
   endfunction

   function automatic void push_ev(input int kind, input logic [2:0] val,
                                   input logic [1:0] src, input int at);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.src  = src;
      e.at   = at;
      ev_q.push_back(e);
   endfunction

   function automatic void push_snap(input int at, input logic [2:0] g, input logic [1:0] s,
                                     input logic b, input logic fs, input logic [2:0] a,
                                     input logic t);
      snap_t x;
      x.at = at;
      x.v  = {g, s, b, fs, a, t};
      snap_q.push_back(x);
   endfunction

   // ---------------- monitor / scoreboard ----------------
   task automatic take_ev(input int kind, input logic [2:0] val);
      ev_t e;
      chk_cnt++;
      if (ev_q.size() == 0) begin
         $display("FAIL unexpected_%s cyc=%0d act val=%b src=%0d, required none",
                  kname(kind), cyc, val, src_sel);
      end else begin
         e = ev_q.pop_front();
         if (e.kind == kind && e.val == val && e.src == src_sel && e.at == cyc) begin
            pass_cnt++;
            $display("txn %s cyc=%0d val=%b src=%0d", kname(kind), cyc, val, src_sel);
         end else begin
            $display("FAIL event act %s val=%b src=%0d cyc=%0d, required %s val=%b src=%0d cyc=%0d",
                     kname(kind), val, src_sel, cyc, kname(e.kind), e.val, e.src, e.at);
         end
      end
   endtask

   task automatic take_snap();
      snap_t       x;
      logic [10:0] act;
      x   = snap_q.pop_front();
      act = {gnt, src_sel, busy, frame_start, ack, timeout};
      chk_cnt++;
      if (x.at == cyc && act == x.v) begin
         pass_cnt++;
      end else begin
         $display("FAIL snapshot cyc=%0d {gnt,src,busy,fs,ack,to} act=%b required=%b at cyc=%0d",
                  cyc, act, x.v, x.at);
      end
   endtask

   always @(negedge sys_clk) begin
      if (frame_start)     take_ev(0, gnt);
      if (ack != 3'b000)   take_ev(1, ack);
      if (timeout)         take_ev(2, 3'b000);
      while (snap_q.size() > 0 && snap_q[0].at <= cyc) take_snap();
      if (fin) begin
         chk_cnt++;
         if (ev_q.size() == 0 && snap_q.size() == 0) begin
            pass_cnt++;
         end else begin
            $display("FAIL leftover act events=%0d snaps=%0d, required 0 and 0",
                     ev_q.size(), snap_q.size());
         end
         $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
         $finish;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic set_req(input logic [2:0] v);
      req     = v;
      req_cyc = cyc;
   endtask

   task automatic pulse_done();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask

   // One-cycle reset; every output must show its reset value right after the edge
   task automatic do_reset();
      sys_rst_n = 1'b0;
      push_snap(cyc + 1, 3'b000, 2'd3, 1'b0, 1'b0, 3'b000, 1'b0);
      tick();
      sys_rst_n  = 1'b1;
      idle_at    = cyc;
      last_start = -1000;
   endtask

   // done_off > 0: frame_done during cycle start+done_off
   // done_off = 0: never finished, watchdog fires at start+TMO
   // done_off < 0: reset asserted during cycle start-done_off
   task automatic frame(input logic [2:0] g, input logic [1:0] s, input int done_off,
                        input int new_req, input bit spur_gap);
      int start, ack_c, idle_c;
      start      = imax(imax(req_cyc + 2, idle_at + 2), last_start + FMIN);
      last_start = start;
      push_ev(0, g, s, start);
      push_snap(start - 1, g, s, 1'b1, 1'b0, 3'b000, 1'b0);
      if (done_off < 0) begin
         wait_until(start - done_off);
         do_reset();
         return;
      end
      ack_c  = (done_off > 0) ? start + done_off + 1 : start + TMO;
      idle_c = ack_c + GAP;
      if (done_off > 0) push_ev(1, g, 2'd3, ack_c);
      else              push_ev(2, 3'b000, 2'd3, ack_c);
      push_snap(ack_c, 3'b000, 2'd3, 1'b1, 1'b0,
                (done_off > 0) ? g : 3'b000, (done_off > 0) ? 1'b0 : 1'b1);
      push_snap(idle_c - 1, 3'b000, 2'd3, 1'b1, 1'b0, 3'b000, 1'b0);
      push_snap(idle_c, 3'b000, 2'd3, 1'b0, 1'b0, 3'b000, 1'b0);
      wait_until(start);
      if (new_req >= 0) set_req(3'(new_req));
      if (done_off > 0) begin
         wait_until(start + done_off);
         pulse_done();
      end
      if (spur_gap) begin
         wait_until(ack_c + 1);
         pulse_done();
      end
      wait_until(idle_c);
      idle_at = idle_c;
   endtask

   initial begin
      do_reset();

      // single request, frame_done 10 cycles after frame_start
      set_req(3'b010);
      frame(3'b010, 2'd1, 10, 0, 1'b0);

      // round-robin from a fresh pointer, spacing limited by the frame period
      do_reset();
      set_req(3'b110);
      frame(3'b010, 2'd1, 5, -1, 1'b0);
      frame(3'b100, 2'd2, 5, -1, 1'b0);
      frame(3'b010, 2'd1, 5, 0, 1'b0);

      // urgent priority; pointer still prefers req[2] after the last req[1]
      // grant, so once req[0] is gone the next grant goes to req[2]
      set_req(3'b111);
      frame(3'b001, 2'd0, 5, -1, 1'b0);
      frame(3'b001, 2'd0, 5, 6, 1'b0);
      frame(3'b100, 2'd2, 5, 0, 1'b0);

      // watchdog: no frame_done at all
      set_req(3'b100);
      frame(3'b100, 2'd2, 0, 0, 1'b0);

      // frame_done on the watchdog terminal cycle, plus a stray pulse in GAP
      set_req(3'b010);
      frame(3'b010, 2'd1, TMO - 1, 0, 1'b1);

      // stray frame_done in IDLE
      push_snap(cyc + 3, 3'b000, 2'd3, 1'b0, 1'b0, 3'b000, 1'b0);
      pulse_done();
      wait_until(cyc + 4);
      idle_at = cyc;

      // reset during SEND, then a fresh req[2] frame
      set_req(3'b100);
      frame(3'b100, 2'd2, -3, -1, 1'b0);
      frame(3'b100, 2'd2, 3, 0, 1'b0);

      repeat (3) tick();
      fin = 1'b1;
   end

endmodule
